// File: rtl/spwm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spwm_pkg
// Purpose : Shared definitions for the sinusoidal-PWM dead-time modulator:
//           default carrier width, default dead time and the 3-bit state
//           encoding of the dead-time generator.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package spwm_pkg;

  localparam int DEF_W           = 8;
  localparam int DEF_DEAD_CYCLES = 4;

  localparam logic [2:0] ENC_OFF      = 3'd0;
  localparam logic [2:0] ENC_DT_TO_HI = 3'd1;
  localparam logic [2:0] ENC_HI       = 3'd2;
  localparam logic [2:0] ENC_DT_TO_LO = 3'd3;
  localparam logic [2:0] ENC_LO       = 3'd4;

  typedef enum logic [2:0] {
    S_OFF      = ENC_OFF,
    S_DT_TO_HI = ENC_DT_TO_HI,
    S_HI       = ENC_HI,
    S_DT_TO_LO = ENC_DT_TO_LO,
    S_LO       = ENC_LO
  } dt_state_t;

endpackage
`default_nettype wire

// File: rtl/dead_time_gen.sv
`default_nettype none
// ============================================================================
// Module  : dead_time_gen
// Purpose : Moore FSM that turns the registered compare result into a
//           complementary half-bridge gate pair with DEAD_CYCLES clocks of
//           both-low at every gate hand-over.
// Ports   : Clk     - system clock (rising edge)
//           Rst_n   - synchronous active-low reset
//           Enable  - run; low forces both gates off on the next edge
//           raw_q   - registered PWM compare result
//           pwm_hi  - high-side gate
//           pwm_lo  - low-side gate
// Rev     : 1.0 - initial release
// ============================================================================
module dead_time_gen
  import spwm_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES   // legal 1 .. 2^W-1
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Enable,
  input  logic raw_q,
  output logic pwm_hi,
  output logic pwm_lo
);

  localparam logic [W-1:0] DEAD_LOAD = W'(DEAD_CYCLES - 1);

  dt_state_t      state, state_nxt;
  logic [W-1:0]   dead_cnt, dead_nxt;
  // Set while leaving OFF: no gate has been driven yet, so the dead window
  // simply runs to completion and the first gate follows raw_q at its end.
  // Without this, a raw_q rise right after enable would abort the window.
  logic           startup, startup_nxt;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= S_OFF;
      dead_cnt <= '0;
      startup  <= 1'b0;
    end else begin
      state    <= state_nxt;
      dead_cnt <= dead_nxt;
      startup  <= startup_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dead_nxt    = dead_cnt;
    startup_nxt = startup;
    if (!Enable) begin
      state_nxt   = S_OFF;
      dead_nxt    = '0;
      startup_nxt = 1'b0;
    end else begin
      case (state)
        S_OFF: begin
          state_nxt   = raw_q ? S_DT_TO_HI : S_DT_TO_LO;
          dead_nxt    = DEAD_LOAD;
          startup_nxt = 1'b1;
        end
        S_LO: begin
          if (raw_q) begin
            state_nxt = S_DT_TO_HI;
            dead_nxt  = DEAD_LOAD;
          end
        end
        S_HI: begin
          if (!raw_q) begin
            state_nxt = S_DT_TO_LO;
            dead_nxt  = DEAD_LOAD;
          end
        end
        S_DT_TO_HI, S_DT_TO_LO: begin
          if (startup) begin
            if (dead_cnt == '0) begin
              state_nxt   = raw_q ? S_HI : S_LO;
              startup_nxt = 1'b0;
            end else begin
              dead_nxt  = dead_cnt - W'(1);
              state_nxt = raw_q ? S_DT_TO_HI : S_DT_TO_LO;
            end
          end else if (state == S_DT_TO_HI) begin
            // A compare pulse shorter than the dead time never reaches the
            // high side; the low side simply resumes.
            if (!raw_q)                 state_nxt = S_LO;
            else if (dead_cnt == '0)    state_nxt = S_HI;
            else                        dead_nxt  = dead_cnt - W'(1);
          end else begin
            if (raw_q)                  state_nxt = S_HI;
            else if (dead_cnt == '0)    state_nxt = S_LO;
            else                        dead_nxt  = dead_cnt - W'(1);
          end
        end
        default: begin
          state_nxt   = S_OFF;
          dead_nxt    = '0;
          startup_nxt = 1'b0;
        end
      endcase
    end
  end

  assign pwm_hi = (state == S_HI);
  assign pwm_lo = (state == S_LO);

endmodule
`default_nettype wire

// File: rtl/spwm_deadtime_modulator.sv
`default_nettype none
// ============================================================================
// Module  : spwm_deadtime_modulator
// Purpose : Sinusoidal PWM modulator. A free-running 2^W-clock carrier is
//           compared against a once-per-period latched sine sample; the
//           compare result drives a complementary gate pair via a dead-time
//           generator.
// Ports   : Clk          - system clock (rising edge)
//           Rst_n        - synchronous active-low reset
//           Enable       - run; low holds the carrier at 0 and gates off
//           sample_in    - offset-binary sine sample (W bits)
//           duty_out     - sample currently applied
//           period_start - one-clock strobe per carrier period
//           pwm_raw      - registered compare result (before dead time)
//           pwm_hi       - high-side gate
//           pwm_lo       - low-side gate
// Rev     : 1.0 - initial release
// ============================================================================
module spwm_deadtime_modulator
  import spwm_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         Enable,
  input  logic [W-1:0] sample_in,
  output logic [W-1:0] duty_out,
  output logic         period_start,
  output logic         pwm_raw,
  output logic         pwm_hi,
  output logic         pwm_lo
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt;
  logic [W-1:0] duty_q;
  logic         raw_q;
  logic         period_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt      <= '0;
      duty_q   <= '0;
      raw_q    <= 1'b0;
      period_q <= 1'b0;
    end else begin
      cnt <= Enable ? cnt + W'(1) : '0;
      // Sample only at the period boundary so a mid-period change of
      // sample_in cannot produce a runt or stretched pulse.
      if (!Enable || (cnt == CNT_MAX))
        duty_q <= sample_in;
      period_q <= Enable && (cnt == '0);
      raw_q    <= Enable && (cnt < duty_q);
    end
  end

  dead_time_gen #(
    .W           (W),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_dead_time_gen (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Enable (Enable),
    .raw_q  (raw_q),
    .pwm_hi (pwm_hi),
    .pwm_lo (pwm_lo)
  );

  assign duty_out     = duty_q;
  assign period_start = period_q;
  assign pwm_raw      = raw_q;

endmodule
`default_nettype wire

// File: tb/tb_spwm_deadtime_modulator.sv
`default_nettype none
// ============================================================================
// Module  : tb_spwm_deadtime_modulator
// Purpose : Directed self-checking bench for spwm_deadtime_modulator
//           (W=8, DEAD_CYCLES=4).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_spwm_deadtime_modulator;

  logic       Clk;
  logic       Rst_n;
  logic       Enable;
  logic [7:0] sample_in;
  logic [7:0] duty_out;
  logic       period_start;
  logic       pwm_raw;
  logic       pwm_hi;
  logic       pwm_lo;

  int checks;
  int fails;

  spwm_deadtime_modulator #(.W(8), .DEAD_CYCLES(4)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Enable       (Enable),
    .sample_in    (sample_in),
    .duty_out     (duty_out),
    .period_start (period_start),
    .pwm_raw      (pwm_raw),
    .pwm_hi       (pwm_hi),
    .pwm_lo       (pwm_lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Shoot-through guard, active for the whole run.
  always @(negedge Clk) begin
    checks++;
    if (pwm_hi && pwm_lo) begin
      fails++;
      $display("FAIL overlap t=%0t pwm_hi=%b pwm_lo=%b required not both 1", $time, pwm_hi, pwm_lo);
    end
  end

  // One clock; outputs are read 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drop Enable for two clocks with the new sample applied, then raise it.
  // The next tick() is the first enabled edge (E0).
  task automatic restart(input logic [7:0] s);
    Enable    = 1'b0;
    sample_in = s;
    ticks(2);
    Enable = 1'b1;
  endtask

  // Measures n clocks of output activity.
  task automatic run_window(input int n, output int raw_c, output int hi_c,
                            output int lo_c, output int both_c,
                            output int runs_c, output int ps_c);
    logic prev_both;
    raw_c = 0; hi_c = 0; lo_c = 0; both_c = 0; runs_c = 0; ps_c = 0;
    prev_both = !pwm_hi && !pwm_lo;
    for (int i = 0; i < n; i++) begin
      tick();
      if (pwm_raw)      raw_c++;
      if (pwm_hi)       hi_c++;
      if (pwm_lo)       lo_c++;
      if (period_start) ps_c++;
      if (!pwm_hi && !pwm_lo) begin
        both_c++;
        if (!prev_both) runs_c++;
      end
      prev_both = !pwm_hi && !pwm_lo;
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; Enable = 1'b0; sample_in = 8'd200;
    ticks(2);
    checks++;
    if ({duty_out, period_start, pwm_raw, pwm_hi, pwm_lo} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs got duty=%0d ps=%b raw=%b hi=%b lo=%b required all 0",
               duty_out, period_start, pwm_raw, pwm_hi, pwm_lo);
    end
    Rst_n = 1'b1; sample_in = 8'd77;
    tick();
    checks++;
    if (duty_out !== 8'd77 || period_start !== 1'b0 || pwm_hi !== 1'b0 || pwm_lo !== 1'b0) begin
      fails++;
      $display("FAIL disabled_tracking got duty=%0d ps=%b hi=%b lo=%b required 77/0/0/0",
               duty_out, period_start, pwm_hi, pwm_lo);
    end
  endtask

  task automatic test_half_duty();
    int r, h, l, b, ru, p;
    restart(8'd128);
    tick(); // E0
    checks++;
    if (period_start !== 1'b1 || pwm_hi !== 1'b0 || pwm_lo !== 1'b0) begin
      fails++;
      $display("FAIL half_e0 got ps=%b hi=%b lo=%b required 1/0/0", period_start, pwm_hi, pwm_lo);
    end
    ticks(3); // E3
    checks++;
    if (pwm_hi !== 1'b0 || pwm_lo !== 1'b0) begin
      fails++;
      $display("FAIL half_dead_e3 got hi=%b lo=%b required 0/0", pwm_hi, pwm_lo);
    end
    tick(); // E4
    checks++;
    if (pwm_hi !== 1'b1) begin
      fails++;
      $display("FAIL half_hi_e4 got hi=%b required 1", pwm_hi);
    end
    ticks(251); // E255
    run_window(256, r, h, l, b, ru, p); // E256..E511
    checks++;
    if (r !== 128 || h !== 124 || l !== 124) begin
      fails++;
      $display("FAIL half_counts got raw=%0d hi=%0d lo=%0d required 128/124/124", r, h, l);
    end
    checks++;
    if (b !== 8 || ru !== 2) begin
      fails++;
      $display("FAIL half_dead got both_low=%0d windows=%0d required 8/2", b, ru);
    end
    checks++;
    if (p !== 1) begin
      fails++;
      $display("FAIL half_period_start got %0d strobes required 1", p);
    end
  endtask

  task automatic test_zero_duty();
    int r, h, l, b, ru, p;
    restart(8'd0);
    ticks(4); // E3
    checks++;
    if (pwm_hi !== 1'b0 || pwm_lo !== 1'b0) begin
      fails++;
      $display("FAIL zero_dead_e3 got hi=%b lo=%b required 0/0", pwm_hi, pwm_lo);
    end
    tick(); // E4
    checks++;
    if (pwm_lo !== 1'b1) begin
      fails++;
      $display("FAIL zero_lo_e4 got lo=%b required 1", pwm_lo);
    end
    run_window(300, r, h, l, b, ru, p);
    checks++;
    if (r !== 0 || h !== 0 || l !== 300) begin
      fails++;
      $display("FAIL zero_counts got raw=%0d hi=%0d lo=%0d required 0/0/300", r, h, l);
    end
  endtask

  task automatic test_narrow_duty();
    int r, h, l, b, ru, p;
    restart(8'd2);
    ticks(256); // E255
    run_window(256, r, h, l, b, ru, p);
    checks++;
    if (r !== 2 || h !== 0 || (256 - l) !== 2) begin
      fails++;
      $display("FAIL narrow_counts got raw=%0d hi=%0d lo_low=%0d required 2/0/2", r, h, 256 - l);
    end
  endtask

  task automatic test_full_duty();
    int r, h, l, b, ru, p;
    restart(8'd255);
    ticks(256);
    run_window(256, r, h, l, b, ru, p);
    checks++;
    if (r !== 255 || l !== 0 || (256 - h) !== 1) begin
      fails++;
      $display("FAIL full_counts got raw=%0d lo=%0d hi_low=%0d required 255/0/1", r, l, 256 - h);
    end
  endtask

  task automatic test_sample_change();
    int r, h, l, b, ru, p;
    restart(8'd128);
    ticks(51); // E50
    sample_in = 8'd64;
    ticks(50); // E100
    checks++;
    if (duty_out !== 8'd128) begin
      fails++;
      $display("FAIL change_mid got duty=%0d required 128", duty_out);
    end
    ticks(154); // E254
    checks++;
    if (duty_out !== 8'd128) begin
      fails++;
      $display("FAIL change_e254 got duty=%0d required 128", duty_out);
    end
    tick(); // E255: carrier now at 0
    checks++;
    if (duty_out !== 8'd64) begin
      fails++;
      $display("FAIL change_e255 got duty=%0d required 64", duty_out);
    end
    run_window(256, r, h, l, b, ru, p);
    checks++;
    if (r !== 64 || h !== 60 || l !== 188) begin
      fails++;
      $display("FAIL change_counts got raw=%0d hi=%0d lo=%0d required 64/60/188", r, h, l);
    end
  endtask

  task automatic test_reset_mid_hi();
    restart(8'd128);
    ticks(101);
    checks++;
    if (pwm_hi !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre got hi=%b required 1", pwm_hi);
    end
    Rst_n = 1'b0;
    tick();
    checks++;
    if ({duty_out, period_start, pwm_raw, pwm_hi, pwm_lo} !== 12'h000) begin
      fails++;
      $display("FAIL rst_mid got duty=%0d ps=%b raw=%b hi=%b lo=%b required all 0",
               duty_out, period_start, pwm_raw, pwm_hi, pwm_lo);
    end
    Rst_n = 1'b1;
    tick(); // E0 with duty 0 latched by reset
    checks++;
    if (period_start !== 1'b1 || pwm_hi !== 1'b0 || pwm_lo !== 1'b0) begin
      fails++;
      $display("FAIL rst_restart_e0 got ps=%b hi=%b lo=%b required 1/0/0", period_start, pwm_hi, pwm_lo);
    end
    ticks(3);
    checks++;
    if (pwm_hi !== 1'b0 || pwm_lo !== 1'b0) begin
      fails++;
      $display("FAIL rst_restart_e3 got hi=%b lo=%b required 0/0", pwm_hi, pwm_lo);
    end
    tick();
    checks++;
    if (pwm_lo !== 1'b1 || pwm_hi !== 1'b0) begin
      fails++;
      $display("FAIL rst_restart_e4 got hi=%b lo=%b required 0/1", pwm_hi, pwm_lo);
    end
  endtask

  task automatic test_disable_mid_hi();
    restart(8'd128);
    ticks(101);
    Enable = 1'b0;
    tick();
    checks++;
    if (pwm_hi !== 1'b0 || pwm_lo !== 1'b0 || pwm_raw !== 1'b0 || period_start !== 1'b0) begin
      fails++;
      $display("FAIL dis_mid got hi=%b lo=%b raw=%b ps=%b required 0/0/0/0",
               pwm_hi, pwm_lo, pwm_raw, period_start);
    end
    Enable = 1'b1;
    tick(); // E0: carrier restarts from 0
    checks++;
    if (period_start !== 1'b1 || pwm_hi !== 1'b0 || pwm_lo !== 1'b0) begin
      fails++;
      $display("FAIL dis_restart_e0 got ps=%b hi=%b lo=%b required 1/0/0", period_start, pwm_hi, pwm_lo);
    end
    ticks(3);
    checks++;
    if (pwm_hi !== 1'b0 || pwm_lo !== 1'b0) begin
      fails++;
      $display("FAIL dis_restart_e3 got hi=%b lo=%b required 0/0", pwm_hi, pwm_lo);
    end
    tick();
    checks++;
    if (pwm_hi !== 1'b1) begin
      fails++;
      $display("FAIL dis_restart_e4 got hi=%b required 1", pwm_hi);
    end
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    Rst_n     = 1'b0;
    Enable    = 1'b0;
    sample_in = 8'd0;
    test_reset();
    test_half_duty();
    test_zero_duty();
    test_narrow_duty();
    test_full_duty();
    test_sample_change();
    test_reset_mid_hi();
    test_disable_mid_hi();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
